// File: rtl/wb_trace_buffer_pkg.sv
// Shared definitions for the writeback trace buffer: register constants and
// small arithmetic helpers used by the top level.
package wb_trace_buffer_pkg;

  // Architectural zero register; never holds state and is optionally not traced.
  localparam logic [4:0] REG_X0 = 5'd0;

  // Saturating 16-bit increment used by the drop counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/wb_trace_buffer_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered storage.
// The head entry is read straight from the storage array, so rdata is valid
// whenever empty is low. Push while full is only honoured together with a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Guard the handshake so an illegal push/pop never corrupts the pointers.
  always_comb begin
    pop_ok_s  = pop && (count_r != {CW{1'b0}});
    push_ok_s = push && ((count_r != CNT_FULL) || pop_ok_s);
  end

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CNT_FULL);
  assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: captures every architectural register write from the
// core, stamps it with a sequence number and queues it for a host to drain.
// A shadow register file mirrors x1..x31 for random-access readback, and a
// sticky overflow flag plus saturating counter record events lost when full.
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int SEQ_W   = 16,
  parameter bit DROP_X0 = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_e,
  input  logic [4:0]             wb_a,
  input  logic [31:0]            wb_d,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SEQ_W-1:0]       out_seq,
  output logic [4:0]             out_addr,
  output logic [31:0]            out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [15:0]            drop_cnt,
  input  logic                   clr_overflow,
  input  logic [4:0]             rf_raddr,
  output logic [31:0]            rf_rdata
);

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [4:0]       addr;
    logic [31:0]      data;
  } wb_event_s;

  localparam logic [SEQ_W-1:0] SEQ_ONE = SEQ_W'(1);

  logic             acc_s;
  logic             push_s;
  logic             pop_s;
  logic             drop_s;
  logic             full_s;
  logic             empty_s;
  logic [SEQ_W-1:0] seq_r;
  logic             overflow_r;
  logic [15:0]      drop_cnt_r;
  logic [31:0]      rf_r [32];
  wb_event_s        wdata_s;
  wb_event_s        rdata_s;

  // Decide which writebacks are traced and how each one is disposed of.
  always_comb begin
    if (DROP_X0 && (wb_a == REG_X0)) begin
      acc_s = 1'b0;
    end else begin
      acc_s = wb_e;
    end
    pop_s   = out_valid && out_ready;
    push_s  = acc_s && (!full_s || pop_s);
    drop_s  = acc_s && full_s && !pop_s;
    wdata_s = '{seq: seq_r, addr: wb_a, data: wb_d};
  end

  sync_fifo #(
    .WIDTH ($bits(wb_event_s)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wdata_s),
    .rdata (rdata_s),
    .count (count),
    .full  (full_s),
    .empty (empty_s)
  );

  assign out_valid = !empty_s;
  assign out_seq   = rdata_s.seq;
  assign out_addr  = rdata_s.addr;
  assign out_data  = rdata_s.data;

  // Sequence number advances on every traced event, stored or dropped, so gaps reveal drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_r <= '0;
    end else if (acc_s) begin
      seq_r <= seq_r + SEQ_ONE;
    end else begin
      seq_r <= seq_r;
    end
  end

  // Overflow bookkeeping; a drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 16'd0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      drop_cnt_r <= clr_overflow ? 16'd1 : sat_inc16(drop_cnt_r);
    end else if (clr_overflow) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 16'd0;
    end else begin
      overflow_r <= overflow_r;
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign overflow = overflow_r;
  assign drop_cnt = drop_cnt_r;

  // Shadow register file tracks every non-x0 writeback regardless of queue state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        rf_r[i] <= 32'd0;
      end
    end else if (wb_e && (wb_a != REG_X0)) begin
      rf_r[wb_a] <= wb_d;
    end else begin
      rf_r[0] <= 32'd0;
    end
  end

  // Readback from the registered array; x0 always reads as zero.
  always_comb begin
    if (rf_raddr == REG_X0) begin
      rf_rdata = 32'd0;
    end else begin
      rf_rdata = rf_r[rf_raddr];
    end
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed self-checking bench for wb_trace_buffer. A second instance with a
// 4-bit sequence number shares the stimulus and is checked for wrap-around.
module tb_wb_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_e;
  logic [4:0]  wb_a;
  logic [31:0] wb_d;
  logic        out_ready;
  logic        clr_overflow;
  logic [4:0]  rf_raddr;

  logic        out_valid;
  logic [15:0] out_seq;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic [31:0] rf_rdata;

  logic        out4_valid;
  logic [3:0]  out4_seq;
  logic [4:0]  out4_addr;
  logic [31:0] out4_data;
  logic [4:0]  count4;
  logic        overflow4;
  logic [15:0] drop_cnt4;
  logic [31:0] rf4_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_trace_buffer #(.DEPTH(16), .SEQ_W(16), .DROP_X0(1'b1)) u_dut (
    .clk(clk), .reset(reset), .wb_e(wb_e), .wb_a(wb_a), .wb_d(wb_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_seq(out_seq),
    .out_addr(out_addr), .out_data(out_data), .count(count),
    .overflow(overflow), .drop_cnt(drop_cnt), .clr_overflow(clr_overflow),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
  );

  wb_trace_buffer #(.DEPTH(16), .SEQ_W(4), .DROP_X0(1'b1)) u_dut4 (
    .clk(clk), .reset(reset), .wb_e(wb_e), .wb_a(wb_a), .wb_d(wb_d),
    .out_valid(out4_valid), .out_ready(out_ready), .out_seq(out4_seq),
    .out_addr(out4_addr), .out_data(out4_data), .count(count4),
    .overflow(overflow4), .drop_cnt(drop_cnt4), .clr_overflow(clr_overflow),
    .rf_raddr(rf_raddr), .rf_rdata(rf4_rdata)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    wb_e         = 1'b0;
    out_ready    = 1'b0;
    clr_overflow = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic put(input logic [4:0] a, input logic [31:0] d);
    wb_e = 1'b1;
    wb_a = a;
    wb_d = d;
    step();
    wb_e = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wb_e = 1'b0; wb_a = 5'd0; wb_d = 32'd0;
    out_ready = 1'b0; clr_overflow = 1'b0; rf_raddr = 5'd5;
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_seq", 32'(out_seq), 32'd0);
    chk("rst_addr", 32'(out_addr), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_rf5", rf_rdata, 32'd0);

    // T1: first capture, shadow RF old value in same cycle
    wb_e = 1'b1; wb_a = 5'd5; wb_d = 32'hDEADBEEF; out_ready = 1'b1;
    #1;
    chk("t1_rf_same_cycle", rf_rdata, 32'd0);
    step();
    wb_e = 1'b0;
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_seq", 32'(out_seq), 32'd0);
    chk("t1_addr", 32'(out_addr), 32'd5);
    chk("t1_data", out_data, 32'hDEADBEEF);
    chk("t1_rf5", rf_rdata, 32'hDEADBEEF);
    chk("t1_count", 32'(count), 32'd1);
    step();
    chk("t1_pop_valid", 32'(out_valid), 32'd0);
    chk("t1_pop_count", 32'(count), 32'd0);

    // T2: x0 writes dropped, not sequenced, x0 reads zero
    rf_raddr = 5'd0;
    put(5'd0, 32'h1234);
    chk("t2_count", 32'(count), 32'd0);
    chk("t2_valid", 32'(out_valid), 32'd0);
    chk("t2_rf0", rf_rdata, 32'd0);
    put(5'd7, 32'h7);
    chk("t2_seq_next", 32'(out_seq), 32'd1);
    step();
    do_reset();
    rf_raddr = 5'd5;
    #1;
    chk("t2_rf_cleared", rf_rdata, 32'd0);

    // T3: overflow with out_ready low, then drain
    out_ready = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      put(5'(i), 32'h100 + 32'(i));
    end
    chk("t3_count", 32'(count), 32'd16);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_drop", 32'(drop_cnt), 32'd2);
    step();
    chk("t3_hold_seq", 32'(out_seq), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("t3_seq", 32'(out_seq), 32'(k));
      chk("t3_addr", 32'(out_addr), 32'(k + 1));
      chk("t3_data", out_data, 32'h100 + 32'(k + 1));
      step();
    end
    chk("t3_empty", 32'(count), 32'd0);
    put(5'd3, 32'h333);
    chk("t3_seq_gap", 32'(out_seq), 32'd18);
    step();

    // T4: full with simultaneous pop and push
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("t4_clr_ovf", 32'(overflow), 32'd0);
    chk("t4_clr_drop", 32'(drop_cnt), 32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      put(5'(i + 1), 32'h200 + 32'(i));
    end
    chk("t4_full", 32'(count), 32'd16);
    out_ready = 1'b1;
    put(5'd20, 32'hABCD);
    out_ready = 1'b0;
    chk("t4_count", 32'(count), 32'd16);
    chk("t4_no_drop", 32'(drop_cnt), 32'd0);
    chk("t4_no_ovf", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("t4_seq", 32'(out_seq), 32'd20 + 32'(k));
      chk("t4_data", out_data, (k < 15) ? (32'h201 + 32'(k)) : 32'hABCD);
      step();
    end
    chk("t4_empty", 32'(count), 32'd0);

    // T5: clear coinciding with a drop
    out_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      put(5'd9, 32'(i));
    end
    chk("t5_drop2", 32'(drop_cnt), 32'd2);
    clr_overflow = 1'b1;
    put(5'd9, 32'h55);
    chk("t5_ovf_win", 32'(overflow), 32'd1);
    chk("t5_drop_win", 32'(drop_cnt), 32'd1);
    step();
    clr_overflow = 1'b0;
    chk("t5_ovf_clr", 32'(overflow), 32'd0);
    chk("t5_drop_clr", 32'(drop_cnt), 32'd0);
    do_reset();

    // T6: 4-bit sequence wraps; continuous drain
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wb_e = 1'b1; wb_a = 5'((i % 31) + 1); wb_d = 32'(i);
      step();
      chk("t6_valid", 32'(out4_valid), 32'd1);
      chk("t6_seq", 32'(out4_seq), 32'(i % 16));
    end
    wb_e = 1'b0;
    out_ready = 1'b0;
    put(5'd1, 32'h1);
    put(5'd2, 32'h2);
    chk("t6_count3", 32'(count4), 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_rst_valid", 32'(out4_valid), 32'd0);
    chk("t6_rst_count", 32'(count4), 32'd0);
    chk("t6_rst_valid16", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
